// File: rtl/adc_cal_pkg.sv
// Shared types and helpers for the ADC calibration sequencer.
package adc_cal_pkg;

    localparam int unsigned MV_W      = 16;
    localparam int unsigned ACC_MAX_W = 24;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        ACCUM,
        COMPUTE,
        LOAD
    } cal_state_t;

    typedef logic        [MV_W-1:0] mv_t;
    typedef logic signed [MV_W-1:0] off_mv_t;
    typedef logic signed [MV_W:0]   diff_mv_t;

    // Signed difference of two unsigned mV readings, one bit wider than the inputs
    function automatic diff_mv_t mv_diff(input mv_t a, input mv_t b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    // True when |d| exceeds the limit
    function automatic logic out_of_range(input diff_mv_t d, input int unsigned lim);
        diff_mv_t lim_s;
        lim_s = $signed((MV_W + 1)'(lim));
        return (d > lim_s) || (d < -lim_s);
    endfunction

endpackage

// File: rtl/adc_cal_chan_acc.sv
// One converter channel: latches the newest reading on its strobe, tracks
// whether a reading is pending for the current set, and sums completed sets.
module adc_cal_chan_acc
    import adc_cal_pkg::*;
#(
    parameter int unsigned ACC_W = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             take,
    input  logic             valid,
    input  logic [MV_W-1:0]  data,
    output logic             fresh,
    output logic [ACC_W-1:0] acc
);

    logic [MV_W-1:0]  val_q, val_d;
    logic             fresh_q, fresh_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [MV_W-1:0]  sample;

    // Latch/accumulate next-state; a same-cycle strobe feeds the sum directly
    always_comb begin
        sample  = valid ? data : val_q;
        val_d   = val_q;
        fresh_d = fresh_q;
        acc_d   = acc_q;
        if (clr) begin
            val_d   = '0;
            fresh_d = 1'b0;
            acc_d   = '0;
        end else begin
            if (valid) begin
                val_d   = data;
                fresh_d = 1'b1;
            end
            if (take) begin
                acc_d   = acc_q + ACC_W'(sample);
                fresh_d = 1'b0;
            end
        end
    end

    // Channel registers
    always_ff @(posedge clk) begin
        if (reset) begin
            val_q   <= '0;
            fresh_q <= 1'b0;
            acc_q   <= '0;
        end else begin
            val_q   <= val_d;
            fresh_q <= fresh_d;
            acc_q   <= acc_d;
        end
    end

    assign fresh = fresh_q;
    assign acc   = acc_q;

endmodule

// File: rtl/adc_cal_sequencer.sv
// Multi-sample one-point calibration of the PWM and R2R ADCs against the XADC.
module adc_cal_sequencer
    import adc_cal_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 100000,
    parameter int unsigned LOG2_N         = 4,
    parameter int unsigned TIMEOUT_CYCLES = 10000000,
    parameter int unsigned OFF_LIMIT      = 500
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cal_start,
    input  logic            cal_abort,
    input  logic [MV_W-1:0] ref_mV,
    input  logic            ref_valid,
    input  logic [MV_W-1:0] pwm_mV,
    input  logic            pwm_valid,
    input  logic [MV_W-1:0] r2r_mV,
    input  logic            r2r_valid,
    output logic [MV_W-1:0] off_pwm,
    output logic [MV_W-1:0] off_r2r,
    output logic            off_load,
    output logic            busy,
    output logic            cal_valid,
    output logic            err_timeout,
    output logic            err_range
);

    localparam int unsigned ACC_W  = MV_W + LOG2_N;
    localparam int unsigned SET_W  = LOG2_N + 1;
    localparam int unsigned N_SETS = 1 << LOG2_N;

    cal_state_t       state_q, state_d;
    logic [31:0]      settle_cnt_q, settle_cnt_d;
    logic [31:0]      tmo_cnt_q, tmo_cnt_d;
    logic [SET_W-1:0] set_cnt_q, set_cnt_d;
    off_mv_t          off_pwm_q, off_pwm_d;
    off_mv_t          off_r2r_q, off_r2r_d;
    logic             cal_valid_q, cal_valid_d;
    logic             err_timeout_q, err_timeout_d;
    logic             err_range_q, err_range_d;

    logic             in_accum;
    logic             start_ok;
    logic             ref_v, pwm_v, r2r_v;
    logic             ref_fresh, pwm_fresh, r2r_fresh;
    logic             take;
    logic             last_set;
    logic             settle_done;
    logic             tmo_hit;
    logic [ACC_W-1:0] acc_ref, acc_pwm, acc_r2r;
    mv_t              avg_ref, avg_pwm, avg_r2r;
    diff_mv_t         d_pwm, d_r2r;
    logic             range_bad;

    // Strobes only count while accumulating; a set closes once every channel has a reading
    always_comb begin
        in_accum    = (state_q == ACCUM);
        start_ok    = (state_q == IDLE) && cal_start && !cal_abort;
        ref_v       = in_accum && ref_valid;
        pwm_v       = in_accum && pwm_valid;
        r2r_v       = in_accum && r2r_valid;
        take        = in_accum && (ref_fresh || ref_v) && (pwm_fresh || pwm_v)
                               && (r2r_fresh || r2r_v);
        last_set    = take && (set_cnt_q == SET_W'(N_SETS - 1));
        settle_done = (settle_cnt_q + 32'd1) >= SETTLE_CYCLES;
        tmo_hit     = (tmo_cnt_q + 32'd1) >= TIMEOUT_CYCLES;
        avg_ref     = MV_W'(acc_ref >> LOG2_N);
        avg_pwm     = MV_W'(acc_pwm >> LOG2_N);
        avg_r2r     = MV_W'(acc_r2r >> LOG2_N);
        d_pwm       = mv_diff(avg_ref, avg_pwm);
        d_r2r       = mv_diff(avg_ref, avg_r2r);
        range_bad   = out_of_range(d_pwm, OFF_LIMIT) || out_of_range(d_r2r, OFF_LIMIT);
    end

    adc_cal_chan_acc #(.ACC_W(ACC_W)) u_acc_ref (
        .clk   (clk),
        .reset (reset),
        .clr   (start_ok),
        .take  (take),
        .valid (ref_v),
        .data  (ref_mV),
        .fresh (ref_fresh),
        .acc   (acc_ref)
    );

    adc_cal_chan_acc #(.ACC_W(ACC_W)) u_acc_pwm (
        .clk   (clk),
        .reset (reset),
        .clr   (start_ok),
        .take  (take),
        .valid (pwm_v),
        .data  (pwm_mV),
        .fresh (pwm_fresh),
        .acc   (acc_pwm)
    );

    adc_cal_chan_acc #(.ACC_W(ACC_W)) u_acc_r2r (
        .clk   (clk),
        .reset (reset),
        .clr   (start_ok),
        .take  (take),
        .valid (r2r_v),
        .data  (r2r_mV),
        .fresh (r2r_fresh),
        .acc   (acc_r2r)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cal_start)   state_d = SETTLE;
            SETTLE:  if (settle_done) state_d = ACCUM;
            ACCUM: begin
                if (last_set)     state_d = COMPUTE;
                else if (tmo_hit) state_d = IDLE;
            end
            COMPUTE: state_d = range_bad ? IDLE : LOAD;
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (cal_abort) state_d = IDLE;
    end

    // Counters, offsets and status flags; abort suppresses any flag or offset update
    always_comb begin
        settle_cnt_d  = settle_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        set_cnt_d     = set_cnt_q;
        off_pwm_d     = off_pwm_q;
        off_r2r_d     = off_r2r_q;
        cal_valid_d   = cal_valid_q;
        err_timeout_d = err_timeout_q;
        err_range_d   = err_range_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    settle_cnt_d  = '0;
                    tmo_cnt_d     = '0;
                    set_cnt_d     = '0;
                    err_timeout_d = 1'b0;
                    err_range_d   = 1'b0;
                end
            end
            SETTLE: settle_cnt_d = settle_cnt_q + 32'd1;
            ACCUM: begin
                tmo_cnt_d = tmo_cnt_q + 32'd1;
                if (take) set_cnt_d = set_cnt_q + SET_W'(1);
                if (!last_set && tmo_hit && !cal_abort) err_timeout_d = 1'b1;
            end
            COMPUTE: begin
                if (!cal_abort) begin
                    if (range_bad) begin
                        err_range_d = 1'b1;
                    end else begin
                        off_pwm_d = off_mv_t'(d_pwm[MV_W-1:0]);
                        off_r2r_d = off_mv_t'(d_r2r[MV_W-1:0]);
                    end
                end
            end
            LOAD: if (!cal_abort) cal_valid_d = 1'b1;
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            settle_cnt_q  <= '0;
            tmo_cnt_q     <= '0;
            set_cnt_q     <= '0;
            off_pwm_q     <= '0;
            off_r2r_q     <= '0;
            cal_valid_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            err_range_q   <= 1'b0;
        end else begin
            settle_cnt_q  <= settle_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            set_cnt_q     <= set_cnt_d;
            off_pwm_q     <= off_pwm_d;
            off_r2r_q     <= off_r2r_d;
            cal_valid_q   <= cal_valid_d;
            err_timeout_q <= err_timeout_d;
            err_range_q   <= err_range_d;
        end
    end

    // State-decoded outputs
    always_comb begin
        busy     = (state_q != IDLE);
        off_load = (state_q == LOAD);
    end

    assign off_pwm     = off_pwm_q;
    assign off_r2r     = off_r2r_q;
    assign cal_valid   = cal_valid_q;
    assign err_timeout = err_timeout_q;
    assign err_range   = err_range_q;

endmodule

// File: tb/tb_adc_cal_sequencer.sv
// Directed self-checking bench for adc_cal_sequencer (LOG2_N=2, settle 10, timeout 200).
module tb_adc_cal_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cal_start, cal_abort;
    logic [15:0] ref_mV, pwm_mV, r2r_mV;
    logic        ref_valid, pwm_valid, r2r_valid;
    logic [15:0] off_pwm, off_r2r;
    logic        off_load, busy, cal_valid, err_timeout, err_range;

    int total = 0;
    int bad = 0;
    int load_cnt = 0;

    adc_cal_sequencer #(
        .SETTLE_CYCLES  (10),
        .LOG2_N         (2),
        .TIMEOUT_CYCLES (200),
        .OFF_LIMIT      (500)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cal_start   (cal_start),
        .cal_abort   (cal_abort),
        .ref_mV      (ref_mV),
        .ref_valid   (ref_valid),
        .pwm_mV      (pwm_mV),
        .pwm_valid   (pwm_valid),
        .r2r_mV      (r2r_mV),
        .r2r_valid   (r2r_valid),
        .off_pwm     (off_pwm),
        .off_r2r     (off_r2r),
        .off_load    (off_load),
        .busy        (busy),
        .cal_valid   (cal_valid),
        .err_timeout (err_timeout),
        .err_range   (err_range)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (off_load === 1'b1) load_cnt <= load_cnt + 1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic rv, input logic pv, input logic qv,
                          input logic [15:0] r, input logic [15:0] p, input logic [15:0] q);
        ref_valid = rv; pwm_valid = pv; r2r_valid = qv;
        ref_mV = r; pwm_mV = p; r2r_mV = q;
        cyc(1);
        ref_valid = 1'b0; pwm_valid = 1'b0; r2r_valid = 1'b0;
    endtask

    task automatic strobe3(input logic [15:0] r, input logic [15:0] p, input logic [15:0] q);
        strobe(1'b1, 1'b1, 1'b1, r, p, q);
    endtask

    // Start pulse, then sit out the 10 settle cycles; returns in the first ACCUM cycle
    task automatic run_start();
        cal_start = 1'b1;
        cyc(1);
        cal_start = 1'b0;
        cyc(10);
    endtask

    // Called in the COMPUTE cycle right after the completing set
    task automatic expect_load(input string tag, input logic [15:0] ep, input logic [15:0] er);
        chk({tag, "_compute_noload"}, {15'd0, off_load}, 16'd0);
        cyc(1);
        chk({tag, "_load_pulse"}, {15'd0, off_load}, 16'd1);
        chk({tag, "_off_pwm"}, off_pwm, ep);
        chk({tag, "_off_r2r"}, off_r2r, er);
        cyc(1);
        chk({tag, "_idle_noload"}, {15'd0, off_load}, 16'd0);
        chk({tag, "_idle_busy"}, {15'd0, busy}, 16'd0);
        chk({tag, "_cal_valid"}, {15'd0, cal_valid}, 16'd1);
    endtask

    initial begin
        reset = 1'b1; cal_start = 1'b0; cal_abort = 1'b0;
        ref_mV = '0; pwm_mV = '0; r2r_mV = '0;
        ref_valid = 1'b0; pwm_valid = 1'b0; r2r_valid = 1'b0;
        cyc(3);
        reset = 1'b0;
        cyc(1);

        // Reset state
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_off_pwm", off_pwm, 16'h0000);
        chk("rst_off_r2r", off_r2r, 16'h0000);
        chk("rst_cal_valid", {15'd0, cal_valid}, 16'd0);
        chk("rst_errs", {14'd0, err_timeout, err_range}, 16'd0);

        // Basic calibration; a strobe during SETTLE must be ignored
        cal_start = 1'b1;
        cyc(1);
        cal_start = 1'b0;
        chk("t1_busy_settle", {15'd0, busy}, 16'd1);
        strobe3(16'd0, 16'd0, 16'd0);
        cyc(9);
        for (int i = 0; i < 4; i++) begin
            cyc(19);
            strobe3(16'd1650, 16'd1600, 16'd1700);
        end
        expect_load("t1", 16'd50, 16'hFFCE);

        // Truncating average: (1000+1001*3)/4 = 1000
        run_start();
        strobe3(16'd1000, 16'd1000, 16'd1000);
        for (int i = 0; i < 3; i++) strobe3(16'd1001, 16'd1000, 16'd1000);
        expect_load("t2", 16'h0000, 16'h0000);

        // Skewed strobes: pwm twice, then ref, then r2r; only the later pwm counts
        run_start();
        strobe(1'b0, 1'b1, 1'b0, 16'd0, 16'd900, 16'd0);
        cyc(1);
        strobe(1'b0, 1'b1, 1'b0, 16'd0, 16'd1000, 16'd0);
        cyc(1);
        strobe(1'b1, 1'b0, 1'b0, 16'd1200, 16'd0, 16'd0);
        cyc(1);
        chk("t3_partial_busy", {15'd0, busy}, 16'd1);
        strobe(1'b0, 1'b0, 1'b1, 16'd0, 16'd0, 16'd1100);
        for (int i = 0; i < 3; i++) strobe3(16'd1200, 16'd1000, 16'd1100);
        expect_load("t3", 16'd200, 16'd100);

        // Boundary: |d| exactly 500 is accepted
        run_start();
        for (int i = 0; i < 4; i++) strobe3(16'd1500, 16'd1000, 16'd2000);
        expect_load("t4a", 16'h01F4, 16'hFE0C);

        // Out of range: d_pwm = 650
        run_start();
        for (int i = 0; i < 4; i++) strobe3(16'd1650, 16'd1000, 16'd1650);
        cyc(1);
        chk("t4b_busy", {15'd0, busy}, 16'd0);
        chk("t4b_err_range", {15'd0, err_range}, 16'd1);
        chk("t4b_off_pwm_kept", off_pwm, 16'h01F4);
        chk("t4b_off_r2r_kept", off_r2r, 16'hFE0C);
        chk("t4b_load_cnt", 16'(load_cnt), 16'd4);

        // Timeout: r2r never strobes; IDLE after the 200th ACCUM cycle
        run_start();
        chk("t5_err_range_clr", {15'd0, err_range}, 16'd0);
        strobe(1'b1, 1'b1, 1'b0, 16'd1650, 16'd1600, 16'd0);
        cyc(198);
        chk("t5_busy_199", {15'd0, busy}, 16'd1);
        chk("t5_tmo_199", {15'd0, err_timeout}, 16'd0);
        cyc(1);
        chk("t5_busy_200", {15'd0, busy}, 16'd0);
        chk("t5_tmo_200", {15'd0, err_timeout}, 16'd1);
        chk("t5_off_pwm_kept", off_pwm, 16'h01F4);

        // Start with abort in the same cycle: abort wins, flag not cleared
        cal_start = 1'b1; cal_abort = 1'b1;
        cyc(1);
        cal_start = 1'b0; cal_abort = 1'b0;
        chk("t5_startabort_busy", {15'd0, busy}, 16'd0);
        chk("t5_startabort_tmo", {15'd0, err_timeout}, 16'd1);

        // Abort mid-ACCUM
        run_start();
        chk("t6_tmo_clr", {15'd0, err_timeout}, 16'd0);
        chk("t6_busy", {15'd0, busy}, 16'd1);
        strobe3(16'd1300, 16'd1300, 16'd1300);
        strobe3(16'd1300, 16'd1300, 16'd1300);
        cal_abort = 1'b1;
        cyc(1);
        cal_abort = 1'b0;
        chk("t6_abort_busy", {15'd0, busy}, 16'd0);
        chk("t6_abort_errs", {14'd0, err_timeout, err_range}, 16'd0);
        cyc(5);
        chk("t6_load_cnt", 16'(load_cnt), 16'd4);
        chk("t6_off_pwm_kept", off_pwm, 16'h01F4);
        chk("t6_off_r2r_kept", off_r2r, 16'hFE0C);

        // cal_start while busy is ignored
        run_start();
        strobe3(16'd1300, 16'd1250, 16'd1350);
        strobe3(16'd1300, 16'd1250, 16'd1350);
        cal_start = 1'b1;
        cyc(1);
        cal_start = 1'b0;
        chk("t7_busy", {15'd0, busy}, 16'd1);
        strobe3(16'd1300, 16'd1250, 16'd1350);
        strobe3(16'd1300, 16'd1250, 16'd1350);
        expect_load("t7", 16'd50, 16'hFFCE);
        chk("t7_load_cnt", 16'(load_cnt), 16'd5);

        // Reset mid-operation
        run_start();
        strobe3(16'd1300, 16'd1250, 16'd1350);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("t8_busy", {15'd0, busy}, 16'd0);
        chk("t8_off_pwm", off_pwm, 16'h0000);
        chk("t8_off_r2r", off_r2r, 16'h0000);
        chk("t8_cal_valid", {15'd0, cal_valid}, 16'd0);
        chk("t8_off_load", {15'd0, off_load}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
